// File: rtl/axi4_slave_mem.sv
// axi4_slave_mem: AXI4 slave RAM with FIXED/INCR/WRAP bursts, byte strobes and OKAY/SLVERR responses.
// Optional LFSR back-pressure on W and R channels when AXI4_SLAVE_MEM_STALL_EN is defined.
module axi4_slave_mem #(
    parameter int          MEM_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        awvalid,
    output logic        awready,
    input  logic [31:0] awaddr,
    input  logic [7:0]  awlen,
    input  logic [2:0]  awsize,
    input  logic [1:0]  awburst,
    input  logic [3:0]  awid,
    input  logic        wvalid,
    output logic        wready,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wlast,
    output logic        bvalid,
    input  logic        bready,
    output logic [1:0]  bresp,
    output logic [3:0]  bid,
    input  logic        arvalid,
    output logic        arready,
    input  logic [31:0] araddr,
    input  logic [7:0]  arlen,
    input  logic [2:0]  arsize,
    input  logic [1:0]  arburst,
    input  logic [3:0]  arid,
    output logic        rvalid,
    input  logic        rready,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rlast,
    output logic [3:0]  rid
);
    localparam int          IW    = $clog2(MEM_WORDS);
    localparam logic [32:0] LIMIT = 33'(MEM_WORDS) * 33'd4;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_DATA} r_state_t;

    logic [31:0] mem [MEM_WORDS];

    function automatic logic in_range(input logic [31:0] a);
        return {1'b0, a - BASE_ADDR} < LIMIT;
    endfunction

    function automatic logic [IW-1:0] widx(input logic [31:0] a);
        return IW'((a - BASE_ADDR) >> 2);
    endfunction

    function automatic logic wrap_ok(input logic [7:0] len);
        return len inside {8'd1, 8'd3, 8'd7, 8'd15};
    endfunction

    // burst-wide errors: bad size, reserved burst type, or WRAP with an illegal length
    function automatic logic burst_err(input logic [2:0] size, input logic [1:0] burst, input logic [7:0] len);
        return size != 3'd2 || burst == 2'b11 || (burst == 2'b10 && !wrap_ok(len));
    endfunction

    // WRAP with a legal length stays inside a (len+1)*4 byte window; everything else but FIXED steps by 4
    function automatic logic [31:0] next_addr(input logic [31:0] a, input logic [7:0] len, input logic [1:0] burst);
        logic [31:0] m;
        m = {22'b0, len, 2'b11};
        return burst == 2'b00 ? a :
               (burst == 2'b10 && wrap_ok(len)) ? ((a & ~m) | ((a + 32'd4) & m)) : a + 32'd4;
    endfunction

    logic w_ok, r_ok;
`ifdef AXI4_SLAVE_MEM_STALL_EN
    logic [7:0] lfsr_q, lfsr_d;
    // Galois LFSR x^8+x^6+x^5+x^4+1, free running
    always_comb lfsr_d = {1'b0, lfsr_q[7:1]} ^ (lfsr_q[0] ? 8'hB8 : 8'h00);
    // LFSR register
    always_ff @(posedge clk or posedge reset) lfsr_q <= reset ? 8'hA5 : lfsr_d;
    assign w_ok = lfsr_q[0];
    assign r_ok = lfsr_q[1];
`else
    assign w_ok = 1'b1;
    assign r_ok = 1'b1;
`endif

    w_state_t    w_state_q, w_state_d;
    logic [31:0] w_addr_q, w_addr_d;
    logic [7:0]  w_len_q, w_len_d, w_cnt_q, w_cnt_d;
    logic [1:0]  w_burst_q, w_burst_d;
    logic [3:0]  w_id_q, w_id_d;
    logic        w_err_q, w_err_d, w_nowr_q, w_nowr_d, mem_we;

    // write FSM next state: latch AW, accept beats until the count reaches len, then respond
    always_comb begin
        w_state_d = w_state_q;
        w_addr_d  = w_addr_q;
        w_len_d   = w_len_q;
        w_cnt_d   = w_cnt_q;
        w_burst_d = w_burst_q;
        w_id_d    = w_id_q;
        w_err_d   = w_err_q;
        w_nowr_d  = w_nowr_q;
        mem_we    = 1'b0;
        case (w_state_q)
            W_IDLE: if (awvalid) begin
                w_state_d = W_DATA;
                w_addr_d  = awaddr;
                w_len_d   = awlen;
                w_burst_d = awburst;
                w_id_d    = awid;
                w_cnt_d   = 8'd0;
                w_err_d   = burst_err(awsize, awburst, awlen);
                w_nowr_d  = awsize != 3'd2;
            end
            W_DATA: if (wvalid && w_ok) begin
                mem_we  = in_range(w_addr_q) && !w_nowr_q;
                w_err_d = w_err_q || !in_range(w_addr_q) || (wlast != (w_cnt_q == w_len_q));
                if (w_cnt_q == w_len_q) w_state_d = W_RESP;
                else begin
                    w_cnt_d  = w_cnt_q + 8'd1;
                    w_addr_d = next_addr(w_addr_q, w_len_q, w_burst_q);
                end
            end
            W_RESP: if (bready) w_state_d = W_IDLE;
            default: w_state_d = W_IDLE;
        endcase
    end

    // write FSM registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            w_state_q <= W_IDLE;
            w_addr_q  <= '0;
            w_len_q   <= '0;
            w_cnt_q   <= '0;
            w_burst_q <= '0;
            w_id_q    <= '0;
            w_err_q   <= 1'b0;
            w_nowr_q  <= 1'b0;
        end else begin
            w_state_q <= w_state_d;
            w_addr_q  <= w_addr_d;
            w_len_q   <= w_len_d;
            w_cnt_q   <= w_cnt_d;
            w_burst_q <= w_burst_d;
            w_id_q    <= w_id_d;
            w_err_q   <= w_err_d;
            w_nowr_q  <= w_nowr_d;
        end
    end

    assign awready = w_state_q == W_IDLE;
    assign wready  = w_state_q == W_DATA && w_ok;
    assign bvalid  = w_state_q == W_RESP;
    assign bresp   = (bvalid && w_err_q) ? 2'b10 : 2'b00;
    assign bid     = bvalid ? w_id_q : 4'd0;

    // RAM write port; contents survive reset
    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++)
            if (mem_we && wstrb[b]) mem[widx(w_addr_q)][8*b +: 8] <= wdata[8*b +: 8];
    end

    r_state_t    r_state_q, r_state_d;
    logic [31:0] r_addr_q, r_addr_d, rdata_q, rdata_d, ld_addr;
    logic [7:0]  r_len_q, r_len_d, r_cnt_q, r_cnt_d, ld_cnt;
    logic [1:0]  r_burst_q, r_burst_d, rresp_q, rresp_d;
    logic [3:0]  r_id_q, r_id_d;
    logic        r_berr_q, r_berr_d, rvalid_q, rvalid_d, rlast_q, rlast_d, ld, ld_ok;

    // read FSM: a beat is loaded into the output registers at the AR handshake, after each
    // non-last R handshake, or later if the load was held off; output regs hold while stalled
    always_comb begin
        r_state_d = r_state_q;
        r_addr_d  = r_addr_q;
        r_len_d   = r_len_q;
        r_cnt_d   = r_cnt_q;
        r_burst_d = r_burst_q;
        r_id_d    = r_id_q;
        r_berr_d  = r_berr_q;
        rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        rlast_d   = rlast_q;
        ld        = 1'b0;
        ld_addr   = r_addr_q;
        ld_cnt    = r_cnt_q;
        if (r_state_q == R_IDLE) begin
            if (arvalid) begin
                r_state_d = R_DATA;
                r_len_d   = arlen;
                r_burst_d = arburst;
                r_id_d    = arid;
                r_berr_d  = burst_err(arsize, arburst, arlen);
                ld_addr   = araddr;
                ld_cnt    = 8'd0;
                ld        = 1'b1;
            end
        end else if (!rvalid_q) begin
            ld = 1'b1;
        end else if (rready) begin
            if (rlast_q) begin
                r_state_d = R_IDLE;
                rvalid_d  = 1'b0;
                rlast_d   = 1'b0;
            end else begin
                ld_addr = next_addr(r_addr_q, r_len_q, r_burst_q);
                ld_cnt  = r_cnt_q + 8'd1;
                ld      = 1'b1;
            end
        end
        ld_ok = in_range(ld_addr) && !r_berr_d;
        if (ld) begin
            r_addr_d = ld_addr;
            r_cnt_d  = ld_cnt;
            rvalid_d = r_ok;
            rdata_d  = r_ok ? (ld_ok ? mem[widx(ld_addr)] : 32'd0) : rdata_q;
            rresp_d  = r_ok ? (ld_ok ? 2'b00 : 2'b10) : rresp_q;
            rlast_d  = r_ok ? ld_cnt == r_len_d : 1'b0;
        end
    end

    // read FSM registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state_q <= R_IDLE;
            r_addr_q  <= '0;
            r_len_q   <= '0;
            r_cnt_q   <= '0;
            r_burst_q <= '0;
            r_id_q    <= '0;
            r_berr_q  <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= '0;
            rlast_q   <= 1'b0;
        end else begin
            r_state_q <= r_state_d;
            r_addr_q  <= r_addr_d;
            r_len_q   <= r_len_d;
            r_cnt_q   <= r_cnt_d;
            r_burst_q <= r_burst_d;
            r_id_q    <= r_id_d;
            r_berr_q  <= r_berr_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            rlast_q   <= rlast_d;
        end
    end

    assign arready = r_state_q == R_IDLE;
    assign rvalid  = rvalid_q;
    assign rdata   = rdata_q;
    assign rresp   = rresp_q;
    assign rlast   = rlast_q;
    assign rid     = r_id_q;
endmodule

// File: doc/axi4_slave_mem.md
Name: axi4_slave_mem

Overview:
- Synthesizable AXI4 slave memory. Consumes the master-side traffic of the testbench AXI4 bus and is the downstream endpoint of that bus.
- Implements a word-addressed RAM with FIXED/INCR/WRAP bursts, byte strobes and OKAY/SLVERR responses.
- Write and read channels run as independent state machines, each with one outstanding transaction.
- Used as the default slave in block-level benches.

Parameters:
- MEM_WORDS, 1024: RAM depth in 32-bit words; valid byte range is 0 .. MEM_WORDS*4-1.
- BASE_ADDR, 32'h0000_0000: byte address mapped to word 0.

Ports:
- clk  input  1  bus clock
- reset  input  1  asynchronous, active-high reset
- awvalid/awready  in/out  1/1  write-address handshake
- awaddr  input  32  burst start byte address
- awlen  input  8  beats minus one
- awsize  input  3  beat size; only 3'b010 supported
- awburst  input  2  00 FIXED, 01 INCR, 10 WRAP
- awid  input  4  write transaction id
- wvalid/wready  in/out  1/1  write-data handshake
- wdata  input  32  write data
- wstrb  input  4  byte enables
- wlast  input  1  last write beat
- bvalid/bready  out/in  1/1  write-response handshake
- bresp  output  2  00 OKAY, 10 SLVERR
- bid  output  4  echoes awid
- arvalid/arready  in/out  1/1  read-address handshake
- araddr, arlen, arsize, arburst, arid  input  32/8/3/2/4  read address/control, same semantics as AW
- rvalid/rready  out/in  1/1  read-data handshake
- rdata  output  32  read data
- rresp  output  2  per-beat response
- rlast  output  1  last read beat
- rid  output  4  echoes arid

Behaviour:
- Reset: async, active-high. All FSMs go to IDLE. awready=1, arready=1; wready, bvalid, rvalid, rlast = 0; bresp, rresp, bid, rid, rdata = 0. RAM contents are not cleared.
- Reset mid-burst aborts the burst silently: no B response, no remaining R beats.
- Write FSM W_IDLE -> W_DATA -> W_RESP -> W_IDLE.
  - W_IDLE: awready=1. On awvalid&&awready, latch addr/len/burst/id, clear the error flag, set beat counter=0, go to W_DATA with wready=1 on the next cycle.
  - W_DATA: each wvalid&&wready beat writes the strobed bytes of the current word. An out-of-range word is not written and sets the error flag.
  - awsize != 2 sets the error flag; data is still accepted, nothing is written.
  - The burst ends when beat counter == len, regardless of wlast. A wlast value that disagrees with the beat count sets the error flag.
  - W_RESP: wready=0, bvalid=1, bresp = error ? SLVERR : OKAY, bid = latched id. bvalid and bid are held until bready, then return to W_IDLE.
  - AW is not accepted outside W_IDLE.
- Read FSM R_IDLE -> R_DATA -> R_IDLE.
  - R_IDLE: on AR handshake, latch control. The next cycle presents beat 0: rvalid=1, rdata = mem[word], rresp per beat, rlast = (len==0).
  - R_DATA: rdata/rresp/rlast are stable while rvalid && !rready. On the rvalid&&rready handshake, the next beat is loaded in the following cycle with no bubble, or the FSM returns to R_IDLE after the rlast beat.
  - Out-of-range beat or arsize != 2: rdata=0, rresp=SLVERR for that beat.
  - Zero-bubble throughput: one beat per cycle while rready=1.
- Address generation per beat (word granularity, 4 bytes):
  - FIXED: address constant.
  - INCR: +4 per beat; 32-bit wrap-around permitted; out-of-range beats are errors.
  - WRAP: the wrap boundary is aligned to (len+1)*4 bytes. A len other than 1, 3, 7 or 15 is treated as INCR and flagged SLVERR.
  - Burst type 2'b11: treated as INCR with SLVERR on all beats.
- Simultaneous same-word read and write in one cycle: the read beat returns the pre-write data; the write commits at that edge.
- Write and read channels are fully concurrent; neither blocks the other.

Optional Feature:
- Macro AXI4_SLAVE_MEM_STALL_EN.
- Defined: an 8-bit Galois LFSR (seed 8'hA5, polynomial x^8+x^6+x^5+x^4+1, advances every cycle, reset to seed) inserts back-pressure.
  - wready in W_DATA is asserted only when lfsr[0]==1.
  - A new rvalid beat (first beat, or next beat after a handshake) is presented only when lfsr[1]==1.
  - Once asserted, rvalid is never dropped before the handshake.
- Undefined: no LFSR is instantiated; wready=1 throughout W_DATA and reads run at full throughput.

Test Plan:
- INCR write then read: AW addr 0x10, len 3, data 0x11111111..0x44444444, wstrb F. Expect bresp OKAY, bid=awid. Read back the same burst: 4 beats in 4 cycles with rready=1, rlast on beat 3, rresp OKAY.
- Strobes: write 0xAABBCCDD with wstrb 4'b0101 over a word holding 0x00000000. Read returns 0x00BB00DD.
- WRAP: write len 3 to addr 0x08, INCR-preloaded values. Beats land at 0x08, 0x0C, 0x00, 0x04. Read WRAP 0x08 len 3 returns the same order.
- Errors:
  - Write to BASE_ADDR + MEM_WORDS*4: bresp SLVERR, memory unchanged.
  - Read len 1 straddling the top word: beat 0 OKAY, beat 1 SLVERR with rdata 0.
  - wlast early on beat 1 of len 3: SLVERR after 4 beats.
- Back-pressure: read len 7 with rready toggling 1/0. rdata, rlast and rresp hold while stalled; all 8 beats arrive in order.
- Reset mid-read: assert reset during beat 2 of len 7. rvalid=0 immediately and arready=1 after release. A following read returns data previously written, confirming RAM is preserved.
